// File: rtl/pipeline_wb_stage.sv
// MEM/WB pipeline register and writeback stage.
// The stage latches the MEM-stage results, extracts sub-word load data,
// selects the register-file write source and drives the regfile write port,
// the WB-to-EX forwarding bus, the load-fault pulse and the retire counter.
//
// Flow control: the stage has no valid/ready handshake. The upstream valid
// (mem_valid_i) is accepted on every rising edge unless stall_i holds the
// stage or flush_i kills it. flush_i beats stall_i. An instruction held in
// the stage commits in the first cycle stall_i is low. Commit, write enable
// and fault outputs are combinational from the stage registers and stall_i.
module pipeline_wb_stage #(
  parameter int XLEN      = 32,
  parameter int REG_AW    = 5,
  parameter int RET_CNT_W = 32
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 stall_i,
  input  logic                 flush_i,
  input  logic                 mem_valid_i,
  input  logic                 mem_reg_write_i,
  input  logic [REG_AW-1:0]    mem_rd_i,
  input  logic [1:0]           mem_wb_sel_i,
  input  logic [2:0]           mem_funct3_i,
  input  logic [XLEN-1:0]      mem_data_read_i,
  input  logic [XLEN-1:0]      mem_alu_result_i,
  input  logic [XLEN-1:0]      mem_pc_i,
  input  logic [XLEN-1:0]      mem_imm_i,
  output logic                 rf_we_o,
  output logic [REG_AW-1:0]    rf_waddr_o,
  output logic [XLEN-1:0]      rf_wdata_o,
  output logic                 fwd_valid_o,
  output logic [REG_AW-1:0]    fwd_rd_o,
  output logic [XLEN-1:0]      fwd_data_o,
  output logic                 load_fault_o,
  output logic [RET_CNT_W-1:0] retire_cnt_o
);

  // Byte-offset width inside one data-memory word (2 for RV32, 3 for RV64).
  localparam int  OFF_W   = $clog2(XLEN / 8);
  localparam bit  IS_RV32 = (XLEN == 32);

  // Write-source encodings.
  localparam logic [1:0] WB_LOAD = 2'b00;
  localparam logic [1:0] WB_ALU  = 2'b01;
  localparam logic [1:0] WB_PC4  = 2'b10;
  localparam logic [1:0] WB_IMM  = 2'b11;

  // RISC-V load funct3 encodings.
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

  // Stage registers.
  logic              valid_q;
  logic              reg_write_q;
  logic [REG_AW-1:0] rd_q;
  logic [1:0]        wb_sel_q;
  logic [2:0]        funct3_q;
  logic [XLEN-1:0]   data_read_q;
  logic [XLEN-1:0]   alu_q;
  logic [XLEN-1:0]   pc_q;
  logic [XLEN-1:0]   imm_q;

  logic [RET_CNT_W-1:0] retire_q;

  // Combinational datapath.
  logic [OFF_W-1:0]  byte_off;
  logic [XLEN-1:0]   lane;
  logic [XLEN-1:0]   load_data;
  logic              illegal_f3;
  logic              misaligned;
  logic              fault;
  logic              commit;
  logic              rd_nonzero;
  logic [XLEN-1:0]   wdata;

  // Pipeline register: reset clears, flush kills valid, stall holds, else capture.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      valid_q     <= 1'b0;
      reg_write_q <= 1'b0;
      rd_q        <= '0;
      wb_sel_q    <= '0;
      funct3_q    <= '0;
      data_read_q <= '0;
      alu_q       <= '0;
      pc_q        <= '0;
      imm_q       <= '0;
    end else if (flush_i) begin
      valid_q     <= 1'b0;
    end else if (!stall_i) begin
      valid_q     <= mem_valid_i;
      reg_write_q <= mem_reg_write_i;
      rd_q        <= mem_rd_i;
      wb_sel_q    <= mem_wb_sel_i;
      funct3_q    <= mem_funct3_i;
      data_read_q <= mem_data_read_i;
      alu_q       <= mem_alu_result_i;
      pc_q        <= mem_pc_i;
      imm_q       <= mem_imm_i;
    end
  end

  // Shift the addressed byte lane down to bit 0.
  always_comb begin
    byte_off = alu_q[OFF_W-1:0];
    lane     = data_read_q >> {byte_off, 3'b000};
  end

  // Size/sign extraction of the shifted lane.
  always_comb begin
    load_data = '0;
    case (funct3_q)
      F3_LB:   load_data = XLEN'($signed(lane[7:0]));
      F3_LH:   load_data = XLEN'($signed(lane[15:0]));
      F3_LW:   load_data = XLEN'($signed(lane[31:0]));
      F3_LD:   load_data = lane;
      F3_LBU:  load_data = XLEN'(lane[7:0]);
      F3_LHU:  load_data = XLEN'(lane[15:0]);
      F3_LWU:  load_data = XLEN'(lane[31:0]);
      default: load_data = '0;
    endcase
  end

  // Illegal encodings and address alignment against the access size.
  always_comb begin
    illegal_f3 = (funct3_q == 3'b111) ||
                 (IS_RV32 && ((funct3_q == F3_LD) || (funct3_q == F3_LWU)));
    misaligned = 1'b0;
    case (funct3_q[1:0])
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = alu_q[0];
      2'b10:   misaligned = |alu_q[1:0];
      default: misaligned = |alu_q[2:0];
    endcase
  end

  // Fault, commit and write-source selection.
  always_comb begin
    fault      = valid_q && (wb_sel_q == WB_LOAD) && (illegal_f3 || misaligned);
    commit     = valid_q && !stall_i && !fault;
    rd_nonzero = (rd_q != '0);
    wdata      = '0;
    case (wb_sel_q)
      WB_LOAD: wdata = load_data;
      WB_ALU:  wdata = alu_q;
      WB_PC4:  wdata = pc_q + XLEN'(4);
      WB_IMM:  wdata = imm_q;
      default: wdata = '0;
    endcase
  end

  // Retire counter: one per committed instruction, wraps at all-ones.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      retire_q <= '0;
    end else if (commit) begin
      retire_q <= retire_q + RET_CNT_W'(1);
    end
  end

  // Output drive; forwarding stays up while stalled so EX can bypass.
  always_comb begin
    rf_we_o      = commit && reg_write_q && rd_nonzero;
    rf_waddr_o   = rd_q;
    rf_wdata_o   = wdata;
    fwd_valid_o  = valid_q && reg_write_q && rd_nonzero && !fault;
    fwd_rd_o     = rd_q;
    fwd_data_o   = wdata;
    load_fault_o = fault && !stall_i;
    retire_cnt_o = retire_q;
  end

endmodule

// File: tb/tb_pipeline_wb_stage.sv
// Directed bench for pipeline_wb_stage. Two instances share one stimulus:
// dut (default parameters) and dut_c4 (4-bit retire counter for the wrap test).
module tb_pipeline_wb_stage;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        flush;
  logic        mem_valid;
  logic        mem_reg_write;
  logic [4:0]  mem_rd;
  logic [1:0]  mem_wb_sel;
  logic [2:0]  mem_funct3;
  logic [31:0] mem_data_read;
  logic [31:0] mem_alu_result;
  logic [31:0] mem_pc;
  logic [31:0] mem_imm;

  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        fwd_valid;
  logic [4:0]  fwd_rd;
  logic [31:0] fwd_data;
  logic        load_fault;
  logic [31:0] retire_cnt;

  logic        c4_rf_we;
  logic [4:0]  c4_rf_waddr;
  logic [31:0] c4_rf_wdata;
  logic        c4_fwd_valid;
  logic [4:0]  c4_fwd_rd;
  logic [31:0] c4_fwd_data;
  logic        c4_load_fault;
  logic [3:0]  c4_retire_cnt;

  int n_checks;
  int n_fail;
  logic [31:0] exp_ret;

  pipeline_wb_stage dut (
    .clk_i(clk), .reset_i(reset), .stall_i(stall), .flush_i(flush),
    .mem_valid_i(mem_valid), .mem_reg_write_i(mem_reg_write), .mem_rd_i(mem_rd),
    .mem_wb_sel_i(mem_wb_sel), .mem_funct3_i(mem_funct3),
    .mem_data_read_i(mem_data_read), .mem_alu_result_i(mem_alu_result),
    .mem_pc_i(mem_pc), .mem_imm_i(mem_imm),
    .rf_we_o(rf_we), .rf_waddr_o(rf_waddr), .rf_wdata_o(rf_wdata),
    .fwd_valid_o(fwd_valid), .fwd_rd_o(fwd_rd), .fwd_data_o(fwd_data),
    .load_fault_o(load_fault), .retire_cnt_o(retire_cnt)
  );

  pipeline_wb_stage #(.XLEN(32), .REG_AW(5), .RET_CNT_W(4)) dut_c4 (
    .clk_i(clk), .reset_i(reset), .stall_i(stall), .flush_i(flush),
    .mem_valid_i(mem_valid), .mem_reg_write_i(mem_reg_write), .mem_rd_i(mem_rd),
    .mem_wb_sel_i(mem_wb_sel), .mem_funct3_i(mem_funct3),
    .mem_data_read_i(mem_data_read), .mem_alu_result_i(mem_alu_result),
    .mem_pc_i(mem_pc), .mem_imm_i(mem_imm),
    .rf_we_o(c4_rf_we), .rf_waddr_o(c4_rf_waddr), .rf_wdata_o(c4_rf_wdata),
    .fwd_valid_o(c4_fwd_valid), .fwd_rd_o(c4_fwd_rd), .fwd_data_o(c4_fwd_data),
    .load_fault_o(c4_load_fault), .retire_cnt_o(c4_retire_cnt)
  );

  // Clock and reset.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks: inputs change on the falling edge; checks happen #1 later.
  task automatic drive_op(input logic rw, input logic [4:0] rd, input logic [1:0] sel,
                          input logic [2:0] f3, input logic [31:0] data,
                          input logic [31:0] alu, input logic [31:0] pc,
                          input logic [31:0] imm);
    @(negedge clk);
    reset = 1'b0; stall = 1'b0; flush = 1'b0;
    mem_valid = 1'b1; mem_reg_write = rw; mem_rd = rd; mem_wb_sel = sel;
    mem_funct3 = f3; mem_data_read = data; mem_alu_result = alu;
    mem_pc = pc; mem_imm = imm;
    #1;
  endtask

  task automatic drive_idle(input logic st, input logic fl, input logic rs);
    @(negedge clk);
    reset = rs; stall = st; flush = fl;
    mem_valid = 1'b0;
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1; stall = 1'b0; flush = 1'b0; mem_valid = 1'b0;
    mem_reg_write = 1'b0; mem_rd = '0; mem_wb_sel = '0; mem_funct3 = '0;
    mem_data_read = '0; mem_alu_result = '0; mem_pc = '0; mem_imm = '0;
    repeat (2) @(posedge clk);
    drive_idle(1'b0, 1'b0, 1'b0);
    exp_ret = 0;
    n_checks++;
    if (rf_we !== 1'b0 || fwd_valid !== 1'b0 || load_fault !== 1'b0) begin
      $display("FAIL reset_ctl: we=%b fwd=%b fault=%b required 0/0/0", rf_we, fwd_valid, load_fault);
      n_fail++;
    end
    n_checks++;
    if (retire_cnt !== 32'd0 || c4_retire_cnt !== 4'd0) begin
      $display("FAIL reset_cnt: got %0d/%0d required 0/0", retire_cnt, c4_retire_cnt);
      n_fail++;
    end
  endtask

  task automatic test_alu_x0;
    drive_op(1'b1, 5'd5, 2'b01, 3'b010, 32'h0, 32'h1234, 32'h0, 32'h0);
    drive_idle(1'b0, 1'b0, 1'b0);
    n_checks++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 32'h0000_1234) begin
      $display("FAIL alu_write: we=%b addr=%0d data=%h required 1/5/00001234", rf_we, rf_waddr, rf_wdata);
      n_fail++;
    end
    n_checks++;
    if (fwd_valid !== 1'b1 || fwd_rd !== 5'd5 || fwd_data !== 32'h0000_1234) begin
      $display("FAIL alu_fwd: v=%b rd=%0d data=%h required 1/5/00001234", fwd_valid, fwd_rd, fwd_data);
      n_fail++;
    end
    drive_op(1'b1, 5'd0, 2'b01, 3'b010, 32'h0, 32'h1234, 32'h0, 32'h0);
    exp_ret = 1;
    n_checks++;
    if (retire_cnt !== exp_ret) begin
      $display("FAIL alu_retire: got %0d required %0d", retire_cnt, exp_ret);
      n_fail++;
    end
    drive_idle(1'b0, 1'b0, 1'b0);
    n_checks++;
    if (rf_we !== 1'b0 || fwd_valid !== 1'b0) begin
      $display("FAIL x0_suppress: we=%b fwd=%b required 0/0", rf_we, fwd_valid);
      n_fail++;
    end
    drive_idle(1'b0, 1'b0, 1'b0);
    exp_ret = 2;
    n_checks++;
    if (retire_cnt !== exp_ret) begin
      $display("FAIL x0_retire: got %0d required %0d", retire_cnt, exp_ret);
      n_fail++;
    end
  endtask

  // Load extraction plus the PC+4 and immediate sources.
  logic [1:0]  v_sel  [7] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 2'b11};
  logic [2:0]  v_f3   [7] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010, 3'b010, 3'b010};
  logic [31:0] v_addr [7] = '{32'h1003, 32'h1001, 32'h1002, 32'h1000, 32'h1000, 32'h1003, 32'h1001};
  logic [31:0] v_exp  [7] = '{32'hFFFF_FF80, 32'h0000_007F, 32'hFFFF_80FF, 32'h0000_7F01,
                              32'h80FF_7F01, 32'h0000_0104, 32'hDEAD_BEEF};

  task automatic test_wdata_sources;
    for (int i = 0; i < 7; i++) begin
      drive_op(1'b1, 5'd7, v_sel[i], v_f3[i], 32'h80FF_7F01, v_addr[i], 32'h0000_0100, 32'hDEAD_BEEF);
      drive_idle(1'b0, 1'b0, 1'b0);
      n_checks++;
      if (rf_we !== 1'b1 || rf_wdata !== v_exp[i] || load_fault !== 1'b0) begin
        $display("FAIL wdata_%0d: we=%b data=%h fault=%b required 1/%h/0", i, rf_we, rf_wdata, load_fault, v_exp[i]);
        n_fail++;
      end
    end
    drive_idle(1'b0, 1'b0, 1'b0);
    exp_ret = exp_ret + 7;
    n_checks++;
    if (retire_cnt !== exp_ret) begin
      $display("FAIL wdata_retire: got %0d required %0d", retire_cnt, exp_ret);
      n_fail++;
    end
  endtask

  // Misaligned LH, misaligned LW, LD and LWU on RV32.
  logic [2:0]  f_f3   [4] = '{3'b001, 3'b010, 3'b011, 3'b110};
  logic [31:0] f_addr [4] = '{32'h1001, 32'h1002, 32'h1000, 32'h1000};

  task automatic test_faults;
    for (int i = 0; i < 4; i++) begin
      drive_op(1'b1, 5'd8, 2'b00, f_f3[i], 32'h80FF_7F01, f_addr[i], 32'h0, 32'h0);
      drive_idle(1'b0, 1'b0, 1'b0);
      n_checks++;
      if (load_fault !== 1'b1 || rf_we !== 1'b0 || fwd_valid !== 1'b0) begin
        $display("FAIL fault_%0d: fault=%b we=%b fwd=%b required 1/0/0", i, load_fault, rf_we, fwd_valid);
        n_fail++;
      end
      drive_idle(1'b0, 1'b0, 1'b0);
      n_checks++;
      if (load_fault !== 1'b0 || retire_cnt !== exp_ret) begin
        $display("FAIL fault_after_%0d: fault=%b cnt=%0d required 0/%0d", i, load_fault, retire_cnt, exp_ret);
        n_fail++;
      end
    end
  endtask

  task automatic test_stall_release;
    drive_op(1'b1, 5'd9, 2'b10, 3'b010, 32'h0, 32'h0, 32'hFFFF_FFFC, 32'h0);
    for (int c = 0; c < 3; c++) begin
      drive_idle(1'b1, 1'b0, 1'b0);
      n_checks++;
      if (rf_we !== 1'b0 || fwd_valid !== 1'b1 || fwd_data !== 32'h0 || retire_cnt !== exp_ret) begin
        $display("FAIL stall_%0d: we=%b fwd=%b data=%h cnt=%0d required 0/1/00000000/%0d",
                 c, rf_we, fwd_valid, fwd_data, retire_cnt, exp_ret);
        n_fail++;
      end
    end
    drive_idle(1'b0, 1'b0, 1'b0);
    n_checks++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd9 || rf_wdata !== 32'h0) begin
      $display("FAIL stall_release: we=%b addr=%0d data=%h required 1/9/00000000", rf_we, rf_waddr, rf_wdata);
      n_fail++;
    end
    drive_idle(1'b0, 1'b0, 1'b0);
    exp_ret = exp_ret + 1;
    n_checks++;
    if (rf_we !== 1'b0 || retire_cnt !== exp_ret) begin
      $display("FAIL stall_once: we=%b cnt=%0d required 0/%0d", rf_we, retire_cnt, exp_ret);
      n_fail++;
    end
  endtask

  task automatic test_flush_reset;
    drive_op(1'b1, 5'd3, 2'b01, 3'b010, 32'h0, 32'h33, 32'h0, 32'h0);
    @(negedge clk);
    stall = 1'b1; flush = 1'b1;
    mem_valid = 1'b1; mem_rd = 5'd4; mem_alu_result = 32'h44;
    #1;
    drive_idle(1'b0, 1'b0, 1'b0);
    n_checks++;
    if (rf_we !== 1'b0 || fwd_valid !== 1'b0) begin
      $display("FAIL flush_over_stall: we=%b fwd=%b required 0/0", rf_we, fwd_valid);
      n_fail++;
    end
    drive_idle(1'b0, 1'b0, 1'b0);
    n_checks++;
    if (retire_cnt !== exp_ret) begin
      $display("FAIL flush_retire: got %0d required %0d", retire_cnt, exp_ret);
      n_fail++;
    end
    drive_op(1'b1, 5'd6, 2'b01, 3'b010, 32'h0, 32'h66, 32'h0, 32'h0);
    drive_idle(1'b1, 1'b0, 1'b0);
    drive_idle(1'b1, 1'b0, 1'b1);
    drive_idle(1'b0, 1'b0, 1'b0);
    exp_ret = 0;
    n_checks++;
    if (rf_we !== 1'b0 || fwd_valid !== 1'b0 || retire_cnt !== exp_ret || c4_retire_cnt !== 4'd0) begin
      $display("FAIL reset_mid_stall: we=%b fwd=%b cnt=%0d c4=%0d required 0/0/0/0",
               rf_we, fwd_valid, retire_cnt, c4_retire_cnt);
      n_fail++;
    end
  endtask

  // 17 back-to-back commits; the 4-bit counter must read 1..15, 0, 1.
  task automatic test_back_to_back_wrap;
    logic [3:0] exp4;
    for (int i = 0; i < 19; i++) begin
      if (i < 17) drive_op(1'b1, 5'(i + 1), 2'b01, 3'b010, 32'h0, 32'(i * 17), 32'h0, 32'h0);
      else        drive_idle(1'b0, 1'b0, 1'b0);
      if (i >= 1 && i <= 17) begin
        n_checks++;
        if (rf_we !== 1'b1 || rf_waddr !== 5'(i) || rf_wdata !== 32'((i - 1) * 17)) begin
          $display("FAIL b2b_write_%0d: we=%b addr=%0d data=%h required 1/%0d/%h",
                   i, rf_we, rf_waddr, rf_wdata, i, 32'((i - 1) * 17));
          n_fail++;
        end
      end
      if (i >= 2) begin
        exp4 = 4'(i - 1);
        n_checks++;
        if (c4_retire_cnt !== exp4 || retire_cnt !== 32'(i - 1)) begin
          $display("FAIL wrap_%0d: c4=%0d cnt=%0d required %0d/%0d",
                   i, c4_retire_cnt, retire_cnt, exp4, i - 1);
          n_fail++;
        end
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_alu_x0();
    test_wdata_sources();
    test_faults();
    test_stall_release();
    test_flush_reset();
    test_back_to_back_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
